banked_ram_rd_streamer: RTL and testbench

BANKED_RAM_RD_STREAMER -- requirements
Module: banked_ram_rd_streamer

---
 rtl/banked_ram_rd_streamer_pkg.sv | 15 +
 rtl/banked_ram_rd_streamer_stream_fifo.sv | 52 +++++
 rtl/banked_ram_rd_streamer.sv | 112 +++++++++++
 tb/tb_banked_ram_rd_streamer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_ram_rd_streamer_pkg.sv
// Shared FSM encoding and sizing helpers for the strided RAM read streamer.
package banked_ram_rd_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Occupancy counters need one extra bit so that "full" (== depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/banked_ram_rd_streamer_stream_fifo.sv
// Power-of-two synchronous FIFO with registered storage; push and pop may coincide at any occupancy.
module stream_fifo
    import banked_ram_rd_streamer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

endmodule

// File: rtl/banked_ram_rd_streamer.sv
// Streams num_words RAM words from base_addr with a fixed stride onto a valid/ready output.
module banked_ram_rd_streamer
    import banked_ram_rd_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [CNT_W-1:0]      num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_read_req,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    localparam int CW = cnt_width(FIFO_DEPTH);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [CNT_W-1:0]      remaining;
    logic                  rd_req_p1;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [CW:0]           occupancy;
    logic                  last_pop;
    logic                  accept_start;

    // Words already buffered plus the one still coming back from the RAM.
    assign occupancy    = {1'b0, fifo_count} + {{CW{1'b0}}, rd_req_p1};
    assign fifo_pop     = m_valid && m_ready;
    assign last_pop     = fifo_pop && (fifo_count == CW'(1)) && !rd_req_p1;
    assign accept_start = (state == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start && (num_words != '0))               state_nxt = ST_ISSUE;
            ST_ISSUE: if (ram_read_req && (remaining == CNT_W'(1))) state_nxt = ST_DRAIN;
            ST_DRAIN: if (last_pop)                                 state_nxt = ST_IDLE;
            default:                                                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != ST_IDLE);
        ram_read_req = (state == ST_ISSUE) && (remaining != '0) && !fifo_full
                       && (occupancy < (CW+1)'(FIFO_DEPTH));
    end

    // Address generator, word counter, read-return tracker and completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr   <= '0;
            remaining <= '0;
            rd_req_p1 <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_req_p1 <= ram_read_req;
            done      <= (accept_start && (num_words == '0)) || ((state == ST_DRAIN) && last_pop);
            if (accept_start) begin
                rd_addr   <= base_addr;
                remaining <= num_words;
            end else if (ram_read_req) begin
                rd_addr   <= rd_addr + stride_q;
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept_start) stride_q <= stride;
    end

    assign ram_read_addr = rd_addr;

    stream_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_req_p1),
        .push_data (ram_read_data),
        .pop       (fifo_pop),
        .pop_data  (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_valid = !fifo_empty;

endmodule

// File: tb/tb_banked_ram_rd_streamer.sv
// Scoreboard bench: stimulus queues expected addresses/words, a negedge monitor checks the DUT.
module tb_banked_ram_rd_streamer;

    localparam int DW = 16;
    localparam int AW = 13;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] stride = '0;
    logic [NW-1:0] num_words = '0;
    logic          busy, done, ram_read_req, m_valid;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_read_data = '0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;

    banked_ram_rd_streamer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CNT_W      (NW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .stride        (stride),
        .num_words     (num_words),
        .busy          (busy),
        .done          (done),
        .ram_read_req  (ram_read_req),
        .ram_read_addr (ram_read_addr),
        .ram_read_data (ram_read_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0, first_req, first_valid, done_cyc;
    int req_count, pops, done_count;
    int ready_mode = 0;
    logic [DW-1:0] salt = '0;
    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] data_q[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return DW'(a) ^ salt;
    endfunction

    // RAM model: data for the strobed address appears one cycle later.
    always @(posedge clk) begin
        if (ram_read_req) ram_read_data <= word_of(ram_read_addr);
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (ram_read_req) begin
                req_count++;
                if (first_req < 0) first_req = cyc;
                if (addr_q.size() == 0) check("extra_read", 1, 0);
                else                    check("rd_addr", 32'(ram_read_addr), 32'(addr_q.pop_front()));
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 1);
                check("stall_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                pops++;
                if (data_q.size() == 0) check("extra_word", 1, 0);
                else                    check("m_data", 32'(m_data), 32'(data_q.pop_front()));
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic start_xfer(input int base, input int str, input int n);
        addr_q.delete();
        data_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = AW'((base + i * str) % (1 << AW));
            addr_q.push_back(a);
            data_q.push_back(word_of(a));
        end
        @(posedge clk);
        #1;
        base_addr   = AW'(base);
        stride      = AW'(str);
        num_words   = NW'(n);
        start       = 1'b1;
        t0          = cyc;
        first_req   = -1;
        first_valid = -1;
        done_cyc    = -1;
        req_count   = 0;
        pops        = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_xfer(input string name, input int n, input int d0);
        int got = 0;
        for (int k = 0; k < n * 30 + 40; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        check({name, "_done_seen"}, got, 1);
        repeat (2) @(negedge clk);
        check({name, "_done_pulses"}, done_count - d0, 1);
        check({name, "_words"}, pops, n);
        check({name, "_addr_left"}, addr_q.size(), 0);
        check({name, "_data_left"}, data_q.size(), 0);
        check({name, "_busy_end"}, 32'(busy), 0);
    endtask

    task automatic run_xfer(input string name, input int base, input int str, input int n, input int mode);
        int d0;
        ready_mode = mode;
        d0 = done_count;
        start_xfer(base, str, n);
        finish_xfer(name, n, d0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, b, s, n;
        done_count = 0;
        req_count  = 0;
        pops       = 0;
        first_req  = -1;
        first_valid = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_req", 32'(ram_read_req), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_addr", 32'(ram_read_addr), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic timing, full throughput.
        salt = 16'h0000;
        run_xfer("basic", 'h10, 1, 8, 0);
        check("basic_first_req", first_req - t0, 1);
        check("basic_first_valid", first_valid - t0, 3);
        check("basic_done_cyc", done_cyc - t0, 11);
        check("basic_reads", req_count, 8);

        salt = 16'h5A3C;
        run_xfer("thru", 'h0ABC, 7, 32, 0);
        check("thru_done_cyc", done_cyc - t0, 35);

        // Address wrap.
        salt = 16'h1234;
        run_xfer("wrap", 'h1FFE, 3, 4, 1);

        // Back-pressure: FIFO fills, reads stop, then resume.
        salt = 16'hBEEF;
        ready_mode = 2;
        d0 = done_count;
        start_xfer('h0200, 2, 10);
        repeat (12) @(negedge clk);
        check("bp_reads_held", req_count, 4);
        check("bp_req_low", 32'(ram_read_req), 0);
        check("bp_valid", 32'(m_valid), 1);
        ready_mode = 1;
        finish_xfer("bp", 10, d0);

        // Zero-length transfer.
        d0 = done_count;
        ready_mode = 0;
        start_xfer('h0100, 1, 0);
        @(negedge clk);
        check("zero_done_c1", 32'(done), 1);
        check("zero_busy_c1", 32'(busy), 0);
        @(negedge clk);
        check("zero_done_c2", 32'(done), 0);
        check("zero_busy_c2", 32'(busy), 0);
        check("zero_reads", req_count, 0);
        check("zero_pulses", done_count - d0, 1);

        // Abort with reset in cycle 5 of a 16-word transfer.
        salt = 16'h0F0F;
        ready_mode = 0;
        d0 = done_count;
        start_xfer('h0300, 1, 16);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_req", 32'(ram_read_req), 0);
        check("abort_valid", 32'(m_valid), 0);
        check("abort_addr", 32'(ram_read_addr), 0);
        addr_q.delete();
        data_q.delete();
        repeat (20) @(negedge clk);
        check("abort_no_done", done_count - d0, 0);
        salt = 16'h7777;
        run_xfer("post_abort", 'h0300, 1, 16, 1);

        // Randomized transfers.
        for (int t = 0; t < 6; t++) begin
            b = $urandom_range(0, (1 << AW) - 1);
            s = $urandom_range(0, (1 << AW) - 1);
            n = $urandom_range(1, 40);
            salt = DW'($urandom);
            run_xfer("rand", b, s, n, 1);
        end

        // Address-as-data, random back-pressure over 64 words.
        salt = 16'h0000;
        run_xfer("addr_data", $urandom_range(0, (1 << AW) - 1), $urandom_range(1, 100), 64, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
